// File: rtl/mips_mc_control.sv
// ============================================================================
//  Module   : mips_mc_control
//  Purpose  : Control FSM for a multi-cycle MIPS datapath. One instruction is
//             fetched, decoded and executed over 3..5 cycles, plus one extra
//             cycle for every FETCH, MEMRD or MEMWR cycle with mem_ready_i low.
//  Ports    : clk, rst_n (async active-low)
//             opcode_i/funct_i - instruction fields, stable DECODE..next FETCH
//             zero_i           - ALU zero flag (same cycle)
//             mem_ready_i      - memory completes the current request
//             mem_req_o/mem_we_o/iord_o         - memory request/write/addr sel
//             ir_write_o/pc_write_o/reg_write_o - datapath write enables
//             reg_dst_o/mem_to_reg_o            - register file selects
//             pc_src_o, alu_src_a_o, alu_src_b_o, alu_control_o - mux/ALU ctrl
//             illegal_instr_o  - one-cycle pulse on an unsupported instruction
//  Config   : MIPS_MC_IMM_LOGIC_EN - adds andi/ori/xori/slti on the IEXEC path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [2:0] alu_src_b_o,
  output logic [5:0] alu_control_o,
  output logic       illegal_instr_o
);

  // Opcodes
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_addi  = 6'b001000;
`ifdef MIPS_MC_IMM_LOGIC_EN
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_xori  = 6'b001110;
  localparam logic [5:0] c_op_slti  = 6'b001010;
`endif

  // ALU operation codes (identical to the R-type funct encodings)
  localparam logic [5:0] c_alu_add = 6'b100000;
  localparam logic [5:0] c_alu_sub = 6'b100010;
  localparam logic [5:0] c_alu_and = 6'b100100;
  localparam logic [5:0] c_alu_or  = 6'b100101;
  localparam logic [5:0] c_alu_xor = 6'b100110;
  localparam logic [5:0] c_alu_nor = 6'b100111;
  localparam logic [5:0] c_alu_slt = 6'b101010;
  localparam logic [5:0] c_alu_sll = 6'b000000;
  localparam logic [5:0] c_alu_srl = 6'b000010;
  localparam logic [5:0] c_alu_sra = 6'b000011;

  // Mux select encodings
  localparam logic [1:0] c_a_pc      = 2'd0;
  localparam logic [1:0] c_a_rs      = 2'd1;
  localparam logic [1:0] c_a_rt      = 2'd2;
  localparam logic [2:0] c_b_rt      = 3'd0;
  localparam logic [2:0] c_b_four    = 3'd1;
  localparam logic [2:0] c_b_sext    = 3'd2;
  localparam logic [2:0] c_b_sext_sh = 3'd3;
`ifdef MIPS_MC_IMM_LOGIC_EN
  localparam logic [2:0] c_b_zext    = 3'd4;
`endif
  localparam logic [2:0] c_b_shamt   = 3'd5;
  localparam logic [1:0] c_pc_aluout = 2'd1;
  localparam logic [1:0] c_pc_jump   = 2'd2;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTEXEC  = 4'd7,
    S_RTWB    = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  state_t state_q, state_d;

  logic funct_ok;
  logic is_shift;

  always_comb begin
    funct_ok = 1'b0;
    case (funct_i)
      c_alu_add, c_alu_sub, c_alu_and, c_alu_or, c_alu_xor,
      c_alu_nor, c_alu_slt, c_alu_sll, c_alu_srl, c_alu_sra: funct_ok = 1'b1;
      default:                                                funct_ok = 1'b0;
    endcase
  end

  // Shifts take their data from rt and their amount from the shamt field.
  assign is_shift = (funct_i == c_alu_sll) || (funct_i == c_alu_srl) ||
                    (funct_i == c_alu_sra);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          c_op_rtype:       state_d = funct_ok ? S_RTEXEC : S_ILLEGAL;
          c_op_lw, c_op_sw: state_d = S_MEMADR;
          c_op_beq, c_op_bne: state_d = S_BRANCH;
          c_op_j:           state_d = S_JUMP;
          c_op_addi:        state_d = S_IEXEC;
`ifdef MIPS_MC_IMM_LOGIC_EN
          c_op_andi, c_op_ori, c_op_xori, c_op_slti: state_d = S_IEXEC;
`endif
          default:          state_d = S_ILLEGAL;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything not lw is a store.
      S_MEMADR:  state_d = (opcode_i == c_op_lw) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready_i ? S_FETCH : S_MEMWR;
      S_RTEXEC:  state_d = S_RTWB;
      S_RTWB:    state_d = S_FETCH;
      S_IEXEC:   state_d = S_IWB;
      S_IWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ILLEGAL: state_d = S_FETCH;
      default:   state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. Outputs follow the state register combinationally so that
  // an asynchronous reset idles every control line within the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    iord_o          = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    pc_src_o        = 2'd0;
    alu_src_a_o     = c_a_pc;
    alu_src_b_o     = c_b_rt;
    alu_control_o   = c_alu_add;
    illegal_instr_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every FETCH cycle, but only committed together
        // with the instruction word once memory answers.
        mem_req_o   = 1'b1;
        alu_src_b_o = c_b_four;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        alu_src_b_o = c_b_sext_sh;
      end
      S_MEMADR: begin
        alu_src_a_o = c_a_rs;
        alu_src_b_o = c_b_sext;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
      end
      S_RTEXEC: begin
        alu_control_o = funct_i;
        alu_src_a_o   = is_shift ? c_a_rt : c_a_rs;
        alu_src_b_o   = is_shift ? c_b_shamt : c_b_rt;
      end
      S_RTWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a_o = c_a_rs;
        alu_src_b_o = c_b_sext;
`ifdef MIPS_MC_IMM_LOGIC_EN
        // Logical immediates are zero-extended; slti compares signed.
        case (opcode_i)
          c_op_andi: begin alu_control_o = c_alu_and; alu_src_b_o = c_b_zext; end
          c_op_ori:  begin alu_control_o = c_alu_or;  alu_src_b_o = c_b_zext; end
          c_op_xori: begin alu_control_o = c_alu_xor; alu_src_b_o = c_b_zext; end
          c_op_slti: begin alu_control_o = c_alu_slt; end
          default:   begin alu_control_o = c_alu_add; end
        endcase
`endif
      end
      S_IWB: begin
        reg_write_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o   = c_a_rs;
        alu_src_b_o   = c_b_rt;
        alu_control_o = c_alu_sub;
        pc_src_o      = c_pc_aluout;
        pc_write_o    = (opcode_i == c_op_bne) ? ~zero_i : zero_i;
      end
      S_JUMP: begin
        pc_src_o   = c_pc_jump;
        pc_write_o = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_instr_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_control.sv
// ============================================================================
//  Module   : tb_mips_mc_control
//  Purpose  : Directed-vector bench for mips_mc_control. The stimulus process
//             drives one cycle of inputs and queues the hand-derived control
//             word expected for that cycle; a monitor pops and compares on
//             each falling edge.
//  Config   : MIPS_MC_IMM_LOGIC_EN selects the ori expectation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mc_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
  logic [1:0] pc_src, alu_src_a;
  logic [2:0] alu_src_b;
  logic [5:0] alu_control;
  logic       illegal_instr;

  mips_mc_control u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .opcode_i        (opcode),
    .funct_i         (funct),
    .zero_i          (zero),
    .mem_ready_i     (mem_ready),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .iord_o          (iord),
    .ir_write_o      (ir_write),
    .pc_write_o      (pc_write),
    .reg_write_o     (reg_write),
    .reg_dst_o       (reg_dst),
    .mem_to_reg_o    (mem_to_reg),
    .pc_src_o        (pc_src),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .alu_control_o   (alu_control),
    .illegal_instr_o (illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word layout:
  // {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
  //  pc_src[1:0], alu_src_a[1:0], alu_src_b[2:0], alu_control[5:0], illegal}
  typedef struct {
    logic [21:0] word;
    string       name;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [21:0] pk(
    input logic mr, input logic we, input logic io, input logic irw,
    input logic pcw, input logic rw, input logic rd, input logic m2r,
    input logic [1:0] ps, input logic [1:0] a, input logic [2:0] b,
    input logic [5:0] alu, input logic ill);
    return {mr, we, io, irw, pcw, rw, rd, m2r, ps, a, b, alu, ill};
  endfunction

  // Hand-derived control words
  logic [21:0] e_idle, e_fetch, e_fetch_wait, e_decode, e_memadr, e_memrd, e_memwb;
  logic [21:0] e_memwr, e_rt_add, e_rt_sll, e_rtwb, e_iexec_add, e_iwb;
  logic [21:0] e_beq_t, e_beq_nt, e_jump, e_illegal, e_iexec_ori;

  initial begin
    e_idle       = pk(0,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 6'b100000, 0);
    e_fetch      = pk(1,0,0,1,1,0,0,0, 2'd0, 2'd0, 3'd1, 6'b100000, 0);
    e_fetch_wait = pk(1,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd1, 6'b100000, 0);
    e_decode     = pk(0,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd3, 6'b100000, 0);
    e_memadr     = pk(0,0,0,0,0,0,0,0, 2'd0, 2'd1, 3'd2, 6'b100000, 0);
    e_memrd      = pk(1,0,1,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 6'b100000, 0);
    e_memwb      = pk(0,0,0,0,0,1,0,1, 2'd0, 2'd0, 3'd0, 6'b100000, 0);
    e_memwr      = pk(1,1,1,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 6'b100000, 0);
    e_rt_add     = pk(0,0,0,0,0,0,0,0, 2'd0, 2'd1, 3'd0, 6'b100000, 0);
    e_rt_sll     = pk(0,0,0,0,0,0,0,0, 2'd0, 2'd2, 3'd5, 6'b000000, 0);
    e_rtwb       = pk(0,0,0,0,0,1,1,0, 2'd0, 2'd0, 3'd0, 6'b100000, 0);
    e_iexec_add  = pk(0,0,0,0,0,0,0,0, 2'd0, 2'd1, 3'd2, 6'b100000, 0);
    e_iwb        = pk(0,0,0,0,0,1,0,0, 2'd0, 2'd0, 3'd0, 6'b100000, 0);
    e_beq_t      = pk(0,0,0,0,1,0,0,0, 2'd1, 2'd1, 3'd0, 6'b100010, 0);
    e_beq_nt     = pk(0,0,0,0,0,0,0,0, 2'd1, 2'd1, 3'd0, 6'b100010, 0);
    e_jump       = pk(0,0,0,0,1,0,0,0, 2'd2, 2'd0, 3'd0, 6'b100000, 0);
    e_illegal    = pk(0,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 6'b100000, 1);
    e_iexec_ori  = pk(0,0,0,0,0,0,0,0, 2'd0, 2'd1, 3'd4, 6'b100101, 0);
  end

  // One cycle of stimulus: drive just after the rising edge, queue expectation.
  task automatic cyc(input logic rn, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [21:0] w,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rn;
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = mr;
    e.word = w;
    e.name = nm;
    q_exp.push_back(e);
  endtask

  // Monitor: compare on the falling edge, decoupled from stimulus.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      logic [21:0] act;
      e = q_exp.pop_front();
      act = {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst,
             mem_to_reg, pc_src, alu_src_a, alu_src_b, alu_control, illegal_instr};
      n_tests++;
      if (act !== e.word) begin
        n_fail++;
        $display("FAIL %s: got %06h expected %06h", e.name, act, e.word);
      end
    end
  end

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;

    // Reset held three cycles, then release: one RESET cycle, then FETCH.
    cyc(0, OP_R, 6'd0, 0, 1, e_idle,  "rst_hold0");
    cyc(0, OP_R, 6'd0, 0, 1, e_idle,  "rst_hold1");
    cyc(0, OP_R, 6'd0, 0, 1, e_idle,  "rst_hold2");
    cyc(1, OP_R, 6'd0, 0, 1, e_idle,  "reset_state");

    // R-type add: 4 cycles
    cyc(1, OP_R, 6'b100000, 0, 1, e_fetch,  "add_fetch");
    cyc(1, OP_R, 6'b100000, 0, 1, e_decode, "add_decode");
    cyc(1, OP_R, 6'b100000, 0, 1, e_rt_add, "add_rtexec");
    cyc(1, OP_R, 6'b100000, 0, 1, e_rtwb,   "add_rtwb");

    // R-type sll: shift uses a=rt, b=shamt
    cyc(1, OP_R, 6'b000000, 0, 1, e_fetch,  "sll_fetch");
    cyc(1, OP_R, 6'b000000, 0, 1, e_decode, "sll_decode");
    cyc(1, OP_R, 6'b000000, 0, 1, e_rt_sll, "sll_rtexec");
    cyc(1, OP_R, 6'b000000, 0, 1, e_rtwb,   "sll_rtwb");

    // lw with three wait cycles in MEMRD: 8 cycles total
    cyc(1, OP_LW, 6'd0, 0, 1, e_fetch,  "lw_fetch");
    cyc(1, OP_LW, 6'd0, 0, 1, e_decode, "lw_decode");
    cyc(1, OP_LW, 6'd0, 0, 1, e_memadr, "lw_memadr");
    cyc(1, OP_LW, 6'd0, 0, 0, e_memrd,  "lw_memrd_w0");
    cyc(1, OP_LW, 6'd0, 0, 0, e_memrd,  "lw_memrd_w1");
    cyc(1, OP_LW, 6'd0, 0, 0, e_memrd,  "lw_memrd_w2");
    cyc(1, OP_LW, 6'd0, 0, 1, e_memrd,  "lw_memrd_done");
    cyc(1, OP_LW, 6'd0, 0, 1, e_memwb,  "lw_memwb");

    // sw with one FETCH wait and one MEMWR wait
    cyc(1, OP_SW, 6'd0, 0, 0, e_fetch_wait, "sw_fetch_wait");
    cyc(1, OP_SW, 6'd0, 0, 1, e_fetch,      "sw_fetch");
    cyc(1, OP_SW, 6'd0, 0, 1, e_decode,     "sw_decode");
    cyc(1, OP_SW, 6'd0, 0, 1, e_memadr,     "sw_memadr");
    cyc(1, OP_SW, 6'd0, 0, 0, e_memwr,      "sw_memwr_wait");
    cyc(1, OP_SW, 6'd0, 0, 1, e_memwr,      "sw_memwr_done");

    // addi
    cyc(1, OP_ADDI, 6'd0, 0, 1, e_fetch,     "addi_fetch");
    cyc(1, OP_ADDI, 6'd0, 0, 1, e_decode,    "addi_decode");
    cyc(1, OP_ADDI, 6'd0, 0, 1, e_iexec_add, "addi_iexec");
    cyc(1, OP_ADDI, 6'd0, 0, 1, e_iwb,       "addi_iwb");

    // beq taken / not taken, bne inverse
    cyc(1, OP_BEQ, 6'd0, 1, 1, e_fetch,  "beq1_fetch");
    cyc(1, OP_BEQ, 6'd0, 1, 1, e_decode, "beq1_decode");
    cyc(1, OP_BEQ, 6'd0, 1, 1, e_beq_t,  "beq_zero1");
    cyc(1, OP_BEQ, 6'd0, 0, 1, e_fetch,  "beq0_fetch");
    cyc(1, OP_BEQ, 6'd0, 0, 1, e_decode, "beq0_decode");
    cyc(1, OP_BEQ, 6'd0, 0, 1, e_beq_nt, "beq_zero0");
    cyc(1, OP_BNE, 6'd0, 1, 1, e_fetch,  "bne1_fetch");
    cyc(1, OP_BNE, 6'd0, 1, 1, e_decode, "bne1_decode");
    cyc(1, OP_BNE, 6'd0, 1, 1, e_beq_nt, "bne_zero1");
    cyc(1, OP_BNE, 6'd0, 0, 1, e_fetch,  "bne0_fetch");
    cyc(1, OP_BNE, 6'd0, 0, 1, e_decode, "bne0_decode");
    cyc(1, OP_BNE, 6'd0, 0, 1, e_beq_t,  "bne_zero0");

    // j
    cyc(1, OP_J, 6'd0, 0, 1, e_fetch,  "j_fetch");
    cyc(1, OP_J, 6'd0, 0, 1, e_decode, "j_decode");
    cyc(1, OP_J, 6'd0, 0, 1, e_jump,   "j_jump");

    // Unsupported funct (jr) -> ILLEGAL
    cyc(1, OP_R, 6'b001000, 0, 1, e_fetch,   "jr_fetch");
    cyc(1, OP_R, 6'b001000, 0, 1, e_decode,  "jr_decode");
    cyc(1, OP_R, 6'b001000, 0, 1, e_illegal, "jr_illegal");

    // ori: illegal by default, IEXEC with OR/zext when enabled
    cyc(1, OP_ORI, 6'd0, 0, 1, e_fetch,  "ori_fetch");
    cyc(1, OP_ORI, 6'd0, 0, 1, e_decode, "ori_decode");
`ifdef MIPS_MC_IMM_LOGIC_EN
    cyc(1, OP_ORI, 6'd0, 0, 1, e_iexec_ori, "ori_iexec");
    cyc(1, OP_ORI, 6'd0, 0, 1, e_iwb,       "ori_iwb");
`else
    cyc(1, OP_ORI, 6'd0, 0, 1, e_illegal,   "ori_illegal");
`endif

    // Reset during a MEMWR wait: controls drop in the same cycle
    cyc(1, OP_SW, 6'd0, 0, 1, e_fetch,  "swr_fetch");
    cyc(1, OP_SW, 6'd0, 0, 1, e_decode, "swr_decode");
    cyc(1, OP_SW, 6'd0, 0, 1, e_memadr, "swr_memadr");
    cyc(1, OP_SW, 6'd0, 0, 0, e_memwr,  "swr_memwr_wait");
    cyc(0, OP_SW, 6'd0, 0, 0, e_idle,   "swr_async_rst");
    cyc(0, OP_SW, 6'd0, 0, 1, e_idle,   "swr_rst_hold");
    cyc(1, OP_R, 6'b100000, 0, 1, e_idle,  "swr_reset_state");
    cyc(1, OP_R, 6'b100000, 0, 1, e_fetch, "swr_refetch");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
    if (q_exp.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q_exp.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
